pc_sequencer: RTL and testbench

Next-PC controller for the 16-bit core. Drives the next_pc input of the PC register every cycle, using the current PC fed back from that register. Arbitrates between sequential fetch, branch, jump, call and return, stall hold, halt and a single-level interrupt. Holds a small hardware return-address stack and the saved exception PC.

---
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequential fetch, branch/jump/call/return, stall, halt and a
// single-level interrupt, with a small return-address stack and saved exception PC.
module pc_sequencer #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VEC   = 'h0000,
   parameter logic [WIDTH-1:0] IRQ_VEC     = 'h0100,
   parameter int               STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pc,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic             call,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             ret,
   input  logic             iret,
   input  logic             halt,
   input  logic             irq,
   output logic [WIDTH-1:0] next_pc,
   output logic             irq_ack,
   output logic             in_isr,
   output logic             halted,
   output logic             stack_overflow,
   output logic             stack_underflow
);

   localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int              SP_W    = IDX_W + 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_ISR  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SP_W-1:0]  r_sp;
   logic [WIDTH-1:0] r_stack [STACK_DEPTH];
   logic [WIDTH-1:0] r_epc;
   logic             r_ovf;
   logic             r_unf;

   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_top;
   logic [WIDTH-1:0] w_next;
   logic [IDX_W-1:0] w_push_idx;
   logic [IDX_W-1:0] w_top_idx;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_irq_entry;
   logic             w_set_ovf;
   logic             w_set_unf;

   assign w_pc_inc   = pc + WIDTH'(1);
   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == SP_FULL);
   // The pointer counts occupied entries; its low bits address the next free slot.
   assign w_push_idx = r_sp[IDX_W-1:0];
   assign w_top_idx  = w_push_idx - IDX_W'(1);
   assign w_top      = r_stack[w_top_idx];

   always_comb begin
      w_next      = w_pc_inc;
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_irq_entry = 1'b0;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;

      if (stall) begin
         w_next = pc;
      end else if (r_state == ST_HALT) begin
         w_next = pc;
         if (irq) w_irq_entry = 1'b1;
      end else if (r_state == ST_ISR && iret) begin
         w_next      = r_epc;
         w_state_nxt = ST_RUN;
      end else if (r_state != ST_ISR && irq) begin
         w_irq_entry = 1'b1;
      end else if (r_state != ST_ISR && halt) begin
         w_next      = pc;
         w_state_nxt = ST_HALT;
      end else if (ret) begin
         if (!w_empty) begin
            w_next = w_top;
            w_pop  = 1'b1;
         end else begin
            w_set_unf = 1'b1;
         end
      end else if (call) begin
         w_next = jump_target;
         if (!w_full) w_push    = 1'b1;
         else         w_set_ovf = 1'b1;
      end else if (jump) begin
         w_next = jump_target;
      end else if (branch_taken) begin
         w_next = branch_target;
      end

      if (w_irq_entry) begin
         w_next      = IRQ_VEC;
         w_state_nxt = ST_ISR;
      end
   end

   assign next_pc         = reset ? RESET_VEC : w_next;
   assign irq_ack         = w_irq_entry & ~reset;
   assign in_isr          = (r_state == ST_ISR);
   assign halted          = (r_state == ST_HALT);
   assign stack_overflow  = r_ovf;
   assign stack_underflow = r_unf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RUN;
         r_sp    <= '0;
         r_epc   <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push)      r_sp <= r_sp + SP_W'(1);
         else if (w_pop)  r_sp <= r_sp - SP_W'(1);
         if (w_irq_entry) r_epc <= pc;
         if (w_set_ovf)   r_ovf <= 1'b1;
         if (w_set_unf)   r_unf <= 1'b1;
      end
   end

   // Stack contents are plain storage; validity is tracked solely by r_sp.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[w_push_idx] <= w_pc_inc;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random control traffic
// compared against a queue-based behavioural model of the next-PC rules.
module tb_pc_sequencer;

   localparam logic [15:0] RESET_VEC = 16'h0000;
   localparam logic [15:0] IRQ_VEC   = 16'h0100;
   localparam int          DEPTH     = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] pc, branch_target, jump_target, next_pc;
   logic        stall, branch_taken, jump, call, ret, iret, halt, irq;
   logic        irq_ack, in_isr, halted, stack_overflow, stack_underflow;

   pc_sequencer #(
      .WIDTH(16), .RESET_VEC(RESET_VEC), .IRQ_VEC(IRQ_VEC), .STACK_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .pc(pc), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .call(call), .jump_target(jump_target),
      .ret(ret), .iret(iret), .halt(halt), .irq(irq),
      .next_pc(next_pc), .irq_ack(irq_ack), .in_isr(in_isr), .halted(halted),
      .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: return addresses in a queue, mode as two flags.
   logic [15:0] m_stack[$];
   logic        m_isr, m_halt, m_ovf, m_unf;
   logic [15:0] m_epc;
   logic [15:0] pc_reg;
   logic [15:0] obs_np;
   logic        obs_ack;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clr_ctl();
      stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
      iret = 0; halt = 0; irq = 0;
      branch_target = 16'h0; jump_target = 16'h0;
   endtask

   task automatic model_clear();
      m_stack.delete();
      m_isr = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_epc = 16'h0;
   endtask

   // Called just after a falling edge. Applies pc, checks, then clocks the model.
   task automatic step();
      logic [15:0] e_np;
      logic        e_ack;
      logic [15:0] n_stack[$];
      logic        n_isr, n_halt, n_ovf, n_unf;
      logic [15:0] n_epc;
      pc = pc_reg;
      #1;
      n_stack = m_stack;
      n_isr = m_isr; n_halt = m_halt; n_ovf = m_ovf; n_unf = m_unf; n_epc = m_epc;
      e_np = pc + 16'd1;
      e_ack = 0;
      if (stall) e_np = pc;
      else if (m_halt) begin
         e_np = pc;
         if (irq) begin e_np = IRQ_VEC; e_ack = 1; n_epc = pc; n_halt = 0; n_isr = 1; end
      end
      else if (m_isr && iret) begin e_np = m_epc; n_isr = 0; end
      else if (!m_isr && irq) begin e_np = IRQ_VEC; e_ack = 1; n_epc = pc; n_isr = 1; end
      else if (!m_isr && halt) begin e_np = pc; n_halt = 1; end
      else if (ret) begin
         if (n_stack.size() > 0) e_np = n_stack.pop_back();
         else n_unf = 1;
      end
      else if (call) begin
         e_np = jump_target;
         if (n_stack.size() < DEPTH) n_stack.push_back(pc + 16'd1);
         else n_ovf = 1;
      end
      else if (jump) e_np = jump_target;
      else if (branch_taken) e_np = branch_target;

      check_eq("next_pc", next_pc, e_np);
      check_eq("irq_ack", irq_ack, e_ack);
      check_eq("in_isr", in_isr, m_isr);
      check_eq("halted", halted, m_halt);
      check_eq("overflow", stack_overflow, m_ovf);
      check_eq("underflow", stack_underflow, m_unf);
      obs_np  = next_pc;
      obs_ack = irq_ack;

      @(posedge clk);
      #1;
      m_stack = n_stack;
      m_isr = n_isr; m_halt = n_halt; m_ovf = n_ovf; m_unf = n_unf; m_epc = n_epc;
      pc_reg = e_np;
      @(negedge clk);
   endtask

   // Asserts reset mid-cycle, checks the asynchronous effect, releases on a falling edge.
   task automatic do_reset();
      #2 reset = 1;
      #1;
      check_eq("rst_next_pc", next_pc, RESET_VEC);
      check_eq("rst_irq_ack", irq_ack, 0);
      check_eq("rst_in_isr", in_isr, 0);
      check_eq("rst_halted", halted, 0);
      check_eq("rst_overflow", stack_overflow, 0);
      check_eq("rst_underflow", stack_underflow, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 0;
      model_clear();
      pc_reg = RESET_VEC;
   endtask

   initial begin
      reset = 1;
      pc = 16'h0;
      clr_ctl();
      model_clear();
      pc_reg = RESET_VEC;
      @(negedge clk);
      do_reset();

      // Sequential fetch out of reset, then an asynchronous reset mid-cycle.
      for (int i = 0; i < 4; i++) step();
      check_eq("seq_after4", obs_np, 16'h0004);
      do_reset();

      // Wrap and stall hold.
      pc_reg = 16'hFFFF; step();
      check_eq("wrap", obs_np, 16'h0000);
      pc_reg = 16'h0010; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall_hold", obs_np, 16'h0010);
      end
      stall = 0; step();
      check_eq("stall_resume", obs_np, 16'h0011);

      // Call beats jump and branch; ret returns, second ret underflows.
      pc_reg = 16'h0050;
      branch_taken = 1; branch_target = 16'h0200;
      jump = 1; call = 1; jump_target = 16'h0400;
      step();
      check_eq("call_prio", obs_np, 16'h0400);
      clr_ctl(); step();
      ret = 1; step();
      check_eq("ret_addr", obs_np, 16'h0051);
      step();
      check_eq("ret_empty", obs_np, 16'h0052);
      check_eq("underflow_set", stack_underflow, 1);
      ret = 0; step(); step();
      check_eq("underflow_sticky", stack_underflow, 1);

      // Five nested calls overflow a four-deep stack; four rets unwind LIFO.
      do_reset();
      pc_reg = 16'h0200;
      for (int i = 0; i < 5; i++) begin
         call = 1; jump_target = 16'h1000 + 16'(i * 16);
         step();
      end
      check_eq("call5_target", obs_np, 16'h1040);
      check_eq("overflow_set", stack_overflow, 1);
      call = 0; ret = 1;
      step(); check_eq("lifo0", obs_np, 16'h1021);
      step(); check_eq("lifo1", obs_np, 16'h1011);
      step(); check_eq("lifo2", obs_np, 16'h1001);
      step(); check_eq("lifo3", obs_np, 16'h0201);
      ret = 0;

      // Interrupt beats jump; held irq does not re-enter; iret resumes.
      pc_reg = 16'h0123; irq = 1; jump = 1; jump_target = 16'h0300;
      step();
      check_eq("irq_vec", obs_np, IRQ_VEC);
      check_eq("irq_ack_pulse", obs_ack, 1);
      jump = 0; step();
      check_eq("irq_no_reentry", obs_ack, 0);
      check_eq("isr_flag", in_isr, 1);
      irq = 0; iret = 1; step();
      check_eq("iret_epc", obs_np, 16'h0123);
      iret = 0; step();
      check_eq("isr_left", in_isr, 0);

      // irq still high after iret is taken from RUN on the next cycle.
      irq = 1; step(); step();
      iret = 1; step();
      iret = 0; step();
      check_eq("irq_after_iret", obs_np, IRQ_VEC);
      irq = 0; iret = 1; step(); iret = 0;

      // Halt, wake by irq, return to the halted pc.
      pc_reg = 16'h0080; halt = 1; step();
      check_eq("halt_hold", obs_np, 16'h0080);
      halt = 0; jump = 1; jump_target = 16'h0777; step();
      check_eq("halted_ignores", obs_np, 16'h0080);
      check_eq("halted_flag", halted, 1);
      jump = 0; irq = 1; step();
      check_eq("halt_wake", obs_np, IRQ_VEC);
      irq = 0; step();
      check_eq("wake_isr", in_isr, 1);
      iret = 1; step();
      check_eq("halt_iret", obs_np, 16'h0080);
      iret = 0;

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         stall         = ($urandom_range(0, 9) == 0);
         irq           = ($urandom_range(0, 15) == 0);
         halt          = ($urandom_range(0, 39) == 0);
         iret          = ($urandom_range(0, 7) == 0);
         ret           = ($urandom_range(0, 5) == 0);
         call          = ($urandom_range(0, 5) == 0);
         jump          = ($urandom_range(0, 7) == 0);
         branch_taken  = ($urandom_range(0, 5) == 0);
         branch_target = 16'($urandom);
         jump_target   = 16'($urandom);
         if ($urandom_range(0, 19) == 0) pc_reg = 16'($urandom);
         if ($urandom_range(0, 99) == 0) pc_reg = 16'hFFFF;
         if ($urandom_range(0, 499) == 0) begin
            clr_ctl();
            do_reset();
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
